// File: rtl/fp_pkg.sv
// Shared floating-point constants and types for the add/sub datapath.
// Also provides the significand builder used by the alignment stage.
package fp_pkg;

  localparam int EXP_W       = 8;
  localparam int FRAC_W      = 23;
  localparam int SIG_W       = 27;
  localparam int ALIGN_CLAMP = 26;
  localparam int SHAMT_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } align_state_t;

  // Hidden bit is implied by a non-zero exponent; the low three bits are G, R, S.
  function automatic logic [SIG_W-1:0] make_sig(input logic [EXP_W-1:0]  exp_f,
                                                input logic [FRAC_W-1:0] frac);
    return {(exp_f != '0), frac, 3'b000};
  endfunction

endpackage

// File: rtl/sticky_shift_right.sv
// Combinational right shifter that folds every bit lost off the bottom
// into bit 0, so the result keeps a correct sticky indication.
module sticky_shift_right
  import fp_pkg::*;
#(
  parameter int W     = SIG_W,
  parameter int AMT_W = SHAMT_W
) (
  input  logic [W-1:0]     value,
  input  logic [AMT_W-1:0] amount,
  output logic [W-1:0]     result
);

  logic [W-1:0] lost_mask;
  logic [W-1:0] shifted;
  logic         sticky;

  always_comb begin
    lost_mask = ~({W{1'b1}} << amount);
    shifted   = value >> amount;
    sticky    = |(value & lost_mask);
    result    = {shifted[W-1:1], shifted[0] | sticky};
  end

endmodule

// File: rtl/align_mantissas.sv
// Mantissa alignment stage: picks the larger-exponent operand as "big" and
// iteratively right-shifts the smaller significand by diff with sticky.
module align_mantissas
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        exp1,
  input  logic [7:0]        exp2,
  input  logic [22:0]       mant1,
  input  logic [22:0]       mant2,
  input  logic [7:0]        diff,
  input  logic [7:0]        exp_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [26:0]       mant_big,
  output logic [26:0]       mant_small,
  output logic [7:0]        exp_out,
  output logic              swapped
);

  localparam logic [SHAMT_W-1:0] STEP_AMT   = SHAMT_W'(SHIFT_STEP);
  localparam logic [EXP_W-1:0]   CLAMP_DIFF = EXP_W'(ALIGN_CLAMP);

  align_state_t       state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [SIG_W-1:0]   mant_big_q, mant_big_d;
  logic [SIG_W-1:0]   mant_small_q, mant_small_d;
  logic [EXP_W-1:0]   exp_out_q, exp_out_d;
  logic               swapped_q, swapped_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;

  logic               swap_in;
  logic [SIG_W-1:0]   sig1;
  logic [SIG_W-1:0]   sig2;
  logic [SIG_W-1:0]   big_sig;
  logic [SIG_W-1:0]   small_sig;
  logic [SHAMT_W-1:0] step_amt;
  logic [SIG_W-1:0]   shifted;

  // mant_small_q doubles as the working register while shifting.
  sticky_shift_right #(
    .W     (SIG_W),
    .AMT_W (SHAMT_W)
  ) u_shift (
    .value  (mant_small_q),
    .amount (step_amt),
    .result (shifted)
  );

  always_comb begin
    swap_in   = (exp2 > exp1);
    sig1      = make_sig(exp1, mant1);
    sig2      = make_sig(exp2, mant2);
    big_sig   = swap_in ? sig2 : sig1;
    small_sig = swap_in ? sig1 : sig2;
    step_amt  = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
  end

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    exp_out_d    = exp_out_q;
    swapped_d    = swapped_q;
    rem_d        = rem_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          swapped_d  = swap_in;
          exp_out_d  = exp_r;
          mant_big_d = big_sig;
          in_ready_d = 1'b0;
          rem_d      = '0;
          if (diff == '0) begin
            mant_small_d = small_sig;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else if (diff >= CLAMP_DIFF) begin
            // Everything shifts out; only the sticky survives.
            mant_small_d = {{(SIG_W-1){1'b0}}, |small_sig};
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else begin
            mant_small_d = small_sig;
            rem_d        = diff[SHAMT_W-1:0];
            state_d      = SHIFT;
          end
        end
      end

      SHIFT: begin
        mant_small_d = shifted;
        rem_d        = rem_q - step_amt;
        if (rem_d == '0) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
      exp_out_q    <= '0;
      swapped_q    <= 1'b0;
      rem_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
      exp_out_q    <= exp_out_d;
      swapped_q    <= swapped_d;
      rem_q        <= rem_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;
  assign exp_out    = exp_out_q;
  assign swapped    = swapped_q;

endmodule

// File: tb/tb_align_mantissas.sv
// Directed bench for align_mantissas: literal expectations per vector plus a
// per-cycle comparison against a whole-shift arithmetic reference model.
module tb_align_mantissas;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  exp1, exp2, diff, exp_r;
  logic [22:0] mant1, mant2;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] mant_big, mant_small;
  logic [7:0]  exp_out;
  logic        swapped;

  int checks = 0;
  int failures = 0;

  align_mantissas #(.SHIFT_STEP(STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .exp1       (exp1),
    .exp2       (exp2),
    .mant1      (mant1),
    .mant2      (mant2),
    .diff       (diff),
    .exp_r      (exp_r),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .exp_out    (exp_out),
    .swapped    (swapped)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the whole alignment in one arithmetic step.
  function automatic longint sig_of(input logic [7:0] e, input logic [22:0] m);
    return ((e != 0) ? 64'h400_0000 : 64'h0) + longint'(m) * 8;
  endfunction

  function automatic longint align_of(input longint sig, input int d);
    longint q;
    if (d == 0) return sig;
    if (d >= 26) return (sig != 0) ? 1 : 0;
    q = sig / (64'd1 << d);
    if ((sig % (64'd1 << d)) != 0) q = q | 1;
    return q;
  endfunction

  bit     m_busy = 0;
  bit     exp_valid = 0;
  int     m_cnt, m_lat;
  longint m_big, m_small;
  bit     m_swap;
  logic [7:0] m_exp;

  initial begin
    bit s_rst, s_iv, s_or;
    logic [7:0] s_e1, s_e2, s_d, s_er;
    logic [22:0] s_m1, s_m2;
    forever begin
      @(posedge clk);
      s_rst = rst; s_iv = in_valid; s_or = out_ready;
      s_e1 = exp1; s_e2 = exp2; s_m1 = mant1; s_m2 = mant2; s_d = diff; s_er = exp_r;
      if (s_rst) begin
        m_busy = 0;
      end else if (m_busy && exp_valid && s_or) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_cnt++;
      end else if (s_iv) begin
        m_swap  = (s_e2 > s_e1);
        m_big   = m_swap ? sig_of(s_e2, s_m2) : sig_of(s_e1, s_m1);
        m_small = align_of(m_swap ? sig_of(s_e1, s_m1) : sig_of(s_e2, s_m2), int'(s_d));
        m_exp   = s_er;
        m_lat   = (s_d == 0 || s_d >= 26) ? 1 : 1 + (int'(s_d) + STEP - 1) / STEP;
        m_cnt   = 1;
        m_busy  = 1;
      end
      exp_valid = m_busy && (m_cnt >= m_lat);
      #1;
      if (s_rst) begin
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", {5'd0, mant_big} | {5'd0, mant_small} | 32'(exp_out) | 32'(swapped), 32'd0);
      end else begin
        checkOutput("model_out_valid", 32'(out_valid), 32'(exp_valid));
        checkOutput("model_in_ready", 32'(in_ready), 32'(!m_busy));
        if (exp_valid) begin
          checkOutput("model_mant_big", 32'(mant_big), 32'(m_big));
          checkOutput("model_mant_small", 32'(mant_small), 32'(m_small));
          checkOutput("model_exp_out", 32'(exp_out), 32'(m_exp));
          checkOutput("model_swapped", 32'(swapped), 32'(m_swap));
        end
      end
    end
  end

  // Issues one operation from IDLE, checks literal results, then releases it after hold cycles.
  task automatic applyStimulus(input logic [7:0] e1, input logic [7:0] e2,
                               input logic [22:0] m1, input logic [22:0] m2,
                               input logic [7:0] d, input logic [7:0] er,
                               input logic [26:0] req_big, input logic [26:0] req_small,
                               input bit req_swap, input int req_lat, input int hold);
    int guard;
    int lat;
    @(negedge clk);
    exp1 = e1; exp2 = e2; mant1 = m1; mant2 = m2; diff = d; exp_r = er;
    in_valid = 1'b1;
    guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (!in_ready && guard < 50);
    if (guard >= 50) checkOutput("accept_timeout", 32'd0, 32'd1);
    #1;
    in_valid = 1'b0;
    exp1 = 8'($urandom); exp2 = 8'($urandom); mant1 = 23'($urandom);
    mant2 = 23'($urandom); diff = 8'($urandom); exp_r = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(req_lat));
    checkOutput("mant_big", 32'(mant_big), 32'(req_big));
    checkOutput("mant_small", 32'(mant_small), 32'(req_small));
    checkOutput("swapped", 32'(swapped), 32'(req_swap));
    checkOutput("exp_out", 32'(exp_out), 32'(er));
    repeat (hold) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    exp1 = '0; exp2 = '0; mant1 = '0; mant2 = '0; diff = '0; exp_r = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(8'h82, 8'h80, 23'h0, 23'h400000, 8'd2, 8'h82, 27'h4000000, 27'h1800000, 1'b0, 2, 0);
    applyStimulus(8'h7F, 8'h89, 23'h000001, 23'h0, 8'd10, 8'h89, 27'h4000000, 27'h0010001, 1'b1, 4, 1);
    applyStimulus(8'h90, 8'h90, 23'h123456, 23'h123456, 8'd0, 8'h90, 27'h491A2B0, 27'h491A2B0, 1'b0, 1, 0);
    applyStimulus(8'hA8, 8'h80, 23'h0, 23'h0, 8'd40, 8'hA8, 27'h4000000, 27'h0000001, 1'b0, 1, 0);
    applyStimulus(8'hA8, 8'h00, 23'h0, 23'h0, 8'd40, 8'hA8, 27'h4000000, 27'h0000000, 1'b0, 1, 0);
    applyStimulus(8'h9A, 8'h80, 23'h0, 23'h0, 8'd26, 8'h9A, 27'h4000000, 27'h0000001, 1'b0, 1, 0);
    applyStimulus(8'h99, 8'h80, 23'h0, 23'h7FFFFF, 8'd25, 8'h99, 27'h4000000, 27'h0000003, 1'b0, 8, 0);
    applyStimulus(8'h84, 8'h80, 23'h0, 23'h000010, 8'd4, 8'h84, 27'h4000000, 27'h0400008, 1'b0, 2, 0);
    applyStimulus(8'h80, 8'h85, 23'h00000F, 23'h7FFFFF, 8'd5, 8'h85, 27'h7FFFFF8, 27'h0200003, 1'b1, 3, 0);

    // Backpressure: op A held in DONE while op B waits on in_valid.
    applyStimulus(8'h82, 8'h80, 23'h0, 23'h400000, 8'd2, 8'h82, 27'h4000000, 27'h1800000, 1'b0, 2, 0);
    @(negedge clk);
    exp1 = 8'h84; exp2 = 8'h80; mant1 = '0; mant2 = 23'h000010; diff = 8'd4; exp_r = 8'h84;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(posedge clk);
    @(negedge clk);
    exp1 = 8'h7F; exp2 = 8'h89; mant1 = 23'h000001; mant2 = '0; diff = 8'd10; exp_r = 8'h89;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_mant_small", 32'(mant_small), 32'h0400008);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_accepted", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_b_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_b_small", 32'(mant_small), 32'h0010001);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset in the second SHIFT cycle of a diff=20 operation.
    @(negedge clk);
    exp1 = 8'h94; exp2 = 8'h80; mant1 = '0; mant2 = 23'h7FFFFF; diff = 8'd20; exp_r = 8'h94;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mid_small", 32'(mant_small), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h70, 8'h70, 23'h0, 23'h7FFFFF, 8'd0, 8'h70, 27'h4000000, 27'h7FFFFF8, 1'b0, 1, 0);

    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/align_mantissas.md
Name: align_mantissas

Overview:
- FP add/sub pipeline stage directly downstream of the exponent comparator.
- Consumes both operands' exponents and mantissas, plus the comparator's exponent difference and larger exponent.
- Restores hidden bits, swaps operands so the larger-exponent operand is "big", and right-shifts the smaller significand by diff with guard/round/sticky bits.
- Multi-cycle iterative shifter with valid/ready handshakes on both sides; output feeds the significand adder.

Parameters:
- SHIFT_STEP, 4, max bit positions shifted per SHIFT cycle (legal 1..26).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operand set valid.
- in_ready  output  1  block can accept; high only in IDLE.
- exp1  input  8  operand 1 biased exponent.
- exp2  input  8  operand 2 biased exponent.
- mant1  input  23  operand 1 fraction field.
- mant2  input  23  operand 2 fraction field.
- diff  input  8  |exp1-exp2| from comparator.
- exp_r  input  8  larger exponent from comparator.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts result.
- mant_big  output  27  {hidden,fraction,3'b000} of larger-exponent operand.
- mant_small  output  27  aligned smaller significand {24 bits, G, R, S}.
- exp_out  output  8  registered exp_r.
- swapped  output  1  1 when operand 2 is "big".

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; mant_big, mant_small, exp_out, swapped all 0. rst has priority over every other event.
- Significand: sig = {hidden, fraction, 3'b000}, where hidden = (exp != 0). Denormal exponent correction is upstream's job.
- swapped = (exp2 > exp1). Ties give swapped=0. big/small are chosen accordingly.
- IDLE: on in_valid && in_ready, register all fields, load the working register with small sig, and set rem = diff.
  - rem==0 -> DONE.
  - diff>=26 -> mant_small = {26'b0, |small_sig}, then DONE.
  - Otherwise -> SHIFT.
- SHIFT: each cycle, shift right by s = min(rem, SHIFT_STEP); rem -= s.
  - New bit0 = OR of old bit0 and every bit shifted past bit0 (sticky).
  - When rem reaches 0 -> DONE.
- DONE: out_valid=1. Outputs stay stable until out_ready; on out_valid && out_ready -> IDLE.
- Latency from accept edge to out_valid: 1 + N cycles. N = 0 if diff==0 or diff>=26, else ceil(diff/SHIFT_STEP).
- in_ready=0 in SHIFT and DONE. Throughput is one operation per (latency+1) cycles minimum.
- Upstream inputs are sampled only on the accept edge; later changes are ignored.
- Reset during SHIFT or DONE aborts the operation and discards the result; in_ready=1 on the next cycle.
- Unsigned arithmetic only. No sign handling; the sign path is carried alongside by the pipeline.

Decomposition:
- Shared package fp_pkg:
  - Constants EXP_W=8, FRAC_W=23, SIG_W=27 (hidden+frac+GRS), ALIGN_CLAMP=26.
  - typedef enum {IDLE, SHIFT, DONE} align_state_t.
- One combinational sub-module sticky_shift_right: SIG_W value and step amount in; shifted value with sticky folded into bit0 out. Reused later by normalization.

Test Plan:
- Basic: exp1=0x82, exp2=0x80, diff=2, exp_r=0x82, mant1=0, mant2=0x400000 -> mant_big=0x4000000, mant_small=0x1800000, swapped=0, exp_out=0x82, out_valid 2 cycles after accept.
- Swap + sticky: exp1=0x7F, exp2=0x89, diff=10, exp_r=0x89, mant1=0x000001, mant2=0 -> swapped=1, mant_big=0x4000000, mant_small=0x0010001, out_valid 4 cycles after accept (SHIFT_STEP=4).
- Equal exponents: exp1=exp2=0x90, diff=0, mant1=0x123456 -> mant_small=0x491A2B0 (unshifted), swapped=0, out_valid 1 cycle after accept.
- Clamp: diff=40, exp1=0xA8, exp2=0x80, mant2=0 -> mant_small=0x0000001, out_valid 1 cycle after accept; with exp2=0 and mant2=0 -> mant_small=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> all outputs stable, in_ready=0, a concurrent in_valid is not accepted; accept happens only after out_ready handshake returns to IDLE.
- Reset mid-op: diff=20, assert rst on the 2nd SHIFT cycle -> next cycle out_valid=0, in_ready=1, all data outputs 0; a following diff=0 operation completes normally.
